// File: rtl/filter_index_encoder.sv
// filter_index_encoder: recovers binary filter indices from per-slot one-hot selects,
// encoding one slot per cycle and flagging any slot that is not exactly one-hot.
module filter_index_encoder #(
    parameter  int NUM_MACRO      = 1,
    parameter  int OUT_CH         = 64,
    parameter  int MAX_NUM_FILTER = 1,
    localparam int BIT_OUT_CH     = $clog2(OUT_CH),
    localparam int NUM_SLOT       = NUM_MACRO * MAX_NUM_FILTER
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_SLOT*OUT_CH-1:0]     demux,
    output logic                           out_valid,
    output logic [NUM_SLOT*BIT_OUT_CH-1:0] which_filter,
    output logic [NUM_SLOT-1:0]            slot_err,
    output logic                           any_err
);

    localparam int CNT_W = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(NUM_SLOT - 1);
    localparam logic [OUT_CH-1:0] VEC_ONE   = OUT_CH'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ENCODE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]                           state;
    logic [CNT_W-1:0]                     slot_cnt;
    logic [NUM_SLOT*OUT_CH-1:0]           frame;
    logic [NUM_SLOT-1:0][BIT_OUT_CH-1:0]  idx_sh;
    logic [NUM_SLOT-1:0]                  err_sh;
    logic [OUT_CH-1:0]                    cur_vec;
    logic [BIT_OUT_CH-1:0]                enc_idx;
    logic                                 enc_err;

    assign in_ready = (state == IDLE);

    // The captured frame is shifted down one slot per cycle, so the slot being
    // encoded always sits in the low OUT_CH bits and no wide slot mux is needed.
    assign cur_vec = frame[OUT_CH-1:0];

    always_comb begin
        enc_idx = '0;
        for (int j = OUT_CH - 1; j >= 0; j--) begin
            if (cur_vec[j]) begin
                enc_idx = BIT_OUT_CH'(j);
            end
        end
        enc_err = (cur_vec == '0) || ((cur_vec & (cur_vec - VEC_ONE)) != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            frame        <= '0;
            idx_sh       <= '0;
            err_sh       <= '0;
            out_valid    <= 1'b0;
            which_filter <= '0;
            slot_err     <= '0;
            any_err      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        frame    <= demux;
                        slot_cnt <= '0;
                        state    <= ENCODE;
                    end
                end
                ENCODE: begin
                    idx_sh[slot_cnt] <= enc_idx;
                    err_sh[slot_cnt] <= enc_err;
                    frame            <= frame >> OUT_CH;
                    slot_cnt         <= slot_cnt + CNT_W'(1);
                    if (slot_cnt == LAST_SLOT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    which_filter <= idx_sh;
                    slot_err     <= err_sh;
                    any_err      <= |err_sh;
                    out_valid    <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_index_encoder.sv
// Randomised bench for filter_index_encoder: a cycle-level reference model built from the
// slot encoding rules and frame latency is compared against the DUT on every falling edge.
module tb_filter_index_encoder;

    localparam int NUM_MACRO      = 2;
    localparam int MAX_NUM_FILTER = 2;
    localparam int OUT_CH         = 64;
    localparam int NUM_SLOT       = NUM_MACRO * MAX_NUM_FILTER;
    localparam int BW             = $clog2(OUT_CH);
    localparam int FW             = NUM_SLOT * OUT_CH;
    localparam int WW             = NUM_SLOT * BW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] demux;
    logic          out_valid;
    logic [WW-1:0] which_filter;
    logic [NUM_SLOT-1:0] slot_err;
    logic          any_err;

    int checks = 0;
    int fails  = 0;
    bit check_en = 1'b1;

    logic [FW-1:0]       m_frame = '0;
    int                  m_busy  = 0;
    logic                m_ov    = 1'b0;
    logic [WW-1:0]       m_wf    = '0;
    logic [NUM_SLOT-1:0] m_err   = '0;
    logic                m_any   = 1'b0;

    filter_index_encoder #(
        .NUM_MACRO(NUM_MACRO),
        .OUT_CH(OUT_CH),
        .MAX_NUM_FILTER(MAX_NUM_FILTER)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .demux(demux),
        .out_valid(out_valid),
        .which_filter(which_filter),
        .slot_err(slot_err),
        .any_err(any_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference encoding: lowest set bit wins, error unless exactly one bit is set.
    function automatic void modelFrame(input logic [FW-1:0] f, output logic [WW-1:0] wf,
                                       output logic [NUM_SLOT-1:0] err);
        wf  = '0;
        err = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            logic [OUT_CH-1:0] v;
            int low;
            v = f[s*OUT_CH +: OUT_CH];
            low = 0;
            while (low < OUT_CH && !v[low]) low++;
            if (low == OUT_CH) low = 0;
            err[s] = ($countones(v) != 1);
            wf[s*BW +: BW] = low[BW-1:0];
        end
    endfunction

    function automatic logic [FW-1:0] randFrame();
        logic [FW-1:0] f;
        f = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            logic [OUT_CH-1:0] v;
            v = '0;
            case ($urandom_range(0, 3))
                0: v[$urandom_range(0, OUT_CH-1)] = 1'b1;
                1: v = '0;
                2: begin
                    v[$urandom_range(0, OUT_CH-1)] = 1'b1;
                    v[$urandom_range(0, OUT_CH-1)] = 1'b1;
                end
                default: v = {$urandom, $urandom};
            endcase
            f[s*OUT_CH +: OUT_CH] = v;
        end
        return f;
    endfunction

    function automatic logic [FW-1:0] decodeWhich(input logic [WW-1:0] wf);
        logic [FW-1:0] f;
        f = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            f[s*OUT_CH + int'(wf[s*BW +: BW])] = 1'b1;
        end
        return f;
    endfunction

    // A frame is busy for NUM_SLOT+1 edges after capture and publishes on the last one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_ov   <= 1'b0;
            m_wf   <= '0;
            m_err  <= '0;
            m_any  <= 1'b0;
        end else begin
            m_ov <= 1'b0;
            if (m_busy == 0) begin
                if (in_valid) begin
                    m_frame <= demux;
                    m_busy  <= NUM_SLOT + 1;
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    logic [WW-1:0]       wf;
                    logic [NUM_SLOT-1:0] er;
                    modelFrame(m_frame, wf, er);
                    m_wf  <= wf;
                    m_err <= er;
                    m_any <= |er;
                    m_ov  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("out_valid", out_valid, m_ov);
            checkOutput("in_ready", in_ready, m_busy == 0);
            checkOutput("which_filter", which_filter, m_wf);
            checkOutput("slot_err", slot_err, m_err);
            checkOutput("any_err", any_err, m_any);
        end
    end

    task automatic applyStimulus(input logic valid, input logic [FW-1:0] data);
        @(negedge clk);
        in_valid = valid;
        demux    = data;
    endtask

    // Leaves the caller on the falling edge right after the publishing edge.
    task automatic sendFrame(input logic [FW-1:0] f);
        applyStimulus(1'b1, f);
        applyStimulus(1'b0, randFrame());
        repeat (4) @(negedge clk);
        checkOutput("ready_low_before_pulse", in_ready, 1'b0);
        checkOutput("no_early_pulse", out_valid, 1'b0);
        @(negedge clk);
    endtask

    logic [FW-1:0] clean_frame;
    logic [FW-1:0] err_frame;
    logic [WW-1:0] wf_word;

    initial begin
        clean_frame = '0;
        clean_frame[0*OUT_CH + 0]  = 1'b1;
        clean_frame[1*OUT_CH + 5]  = 1'b1;
        clean_frame[2*OUT_CH + 63] = 1'b1;
        clean_frame[3*OUT_CH + 17] = 1'b1;
        err_frame = '0;
        err_frame[0*OUT_CH + 9]  = 1'b1;
        err_frame[2*OUT_CH + 3]  = 1'b1;
        err_frame[2*OUT_CH + 40] = 1'b1;
        err_frame[3*OUT_CH + 63] = 1'b1;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        demux    = '0;
        repeat (4) applyStimulus(1'($urandom), randFrame());
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_which", which_filter, '0);
        checkOutput("reset_slot_err", slot_err, '0);
        checkOutput("reset_any_err", any_err, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        $display("[TB] clean frame");
        sendFrame(clean_frame);
        checkOutput("clean_pulse", out_valid, 1'b1);
        checkOutput("clean_ready_on_pulse", in_ready, 1'b1);
        checkOutput("clean_which", which_filter, {6'd17, 6'd63, 6'd5, 6'd0});
        checkOutput("clean_slot_err", slot_err, 4'b0000);
        checkOutput("clean_any_err", any_err, 1'b0);
        @(negedge clk);
        checkOutput("clean_pulse_end", out_valid, 1'b0);
        checkOutput("clean_hold", which_filter, {6'd17, 6'd63, 6'd5, 6'd0});

        $display("[TB] error frame");
        sendFrame(err_frame);
        checkOutput("err_pulse", out_valid, 1'b1);
        checkOutput("err_which", which_filter, {6'd63, 6'd3, 6'd0, 6'd9});
        checkOutput("err_slot_err", slot_err, 4'b0110);
        checkOutput("err_any_err", any_err, 1'b1);

        $display("[TB] continuous in_valid");
        repeat (20) applyStimulus(1'b1, randFrame());
        applyStimulus(1'b0, '0);
        repeat (8) @(negedge clk);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, clean_frame);
        applyStimulus(1'b0, randFrame());
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_no_pulse", out_valid, 1'b0);
        checkOutput("abort_cleared", which_filter, '0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        sendFrame(clean_frame);
        checkOutput("after_abort_pulse", out_valid, 1'b1);
        checkOutput("after_abort_which", which_filter, {6'd17, 6'd63, 6'd5, 6'd0});

        $display("[TB] decoder round trip");
        for (int n = 0; n < 500; n++) begin
            wf_word = WW'({$urandom, $urandom});
            sendFrame(decodeWhich(wf_word));
            checkOutput("rt_pulse", out_valid, 1'b1);
            checkOutput("rt_which", which_filter, wf_word);
            checkOutput("rt_any_err", any_err, 1'b0);
        end

        repeat (3) @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
